// File: rtl/playfield_pkg.sv
// Shared types and constants for the playfield RAM read-side scanner.
package playfield_pkg;

    localparam int unsigned PF_ROWS         = 20;
    localparam int unsigned PF_COLS         = 12;
    localparam int unsigned PF_READ_LATENCY = 2;
    localparam int unsigned ROW_AW          = 5;
    localparam int unsigned COL_W           = 4;

    typedef logic [ROW_AW-1:0]  row_addr_t;
    typedef logic [COL_W-1:0]   col_idx_t;
    typedef logic [PF_COLS-1:0] row_word_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_STREAM,
        ST_FINISH
    } scan_state_t;

    // Number of set bits in a 32-bit vector.
    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = 6'(n + 6'(v[i]));
        end
        return n;
    endfunction

endpackage

// File: rtl/row_serializer.sv
// Turns one captured playfield row into a valid/ready stream of cells, column 0 first (MSB).
module row_serializer
    import playfield_pkg::*;
#(
    parameter int unsigned COLS = PF_COLS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_i,
    input  logic [COLS-1:0] row_word_i,
    input  row_addr_t       row_idx_i,
    input  logic            ready_i,
    output logic            valid_o,
    output col_idx_t        x_o,
    output row_addr_t       y_o,
    output logic            on_o,
    output logic            last_hs_c
);

    logic            valid_q, valid_d;
    col_idx_t        col_q, col_d;
    row_addr_t       row_q, row_d;
    logic [COLS-1:0] buf_q, buf_d;

    logic hs_c;
    assign hs_c      = valid_q && ready_i;
    assign last_hs_c = hs_c && (col_q == col_idx_t'(COLS - 1));

    // Stream register: load a row, then shift one cell out per handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
            buf_q   <= '0;
        end else begin
            valid_q <= valid_d;
            col_q   <= col_d;
            row_q   <= row_d;
            buf_q   <= buf_d;
        end
    end

    // Next-state for the stream; outputs stay put while valid and not ready.
    always_comb begin
        valid_d = valid_q;
        col_d   = col_q;
        row_d   = row_q;
        buf_d   = buf_q;
        if (load_i) begin
            valid_d = 1'b1;
            col_d   = '0;
            row_d   = row_idx_i;
            buf_d   = row_word_i;
        end else if (hs_c) begin
            buf_d = buf_q << 1;
            if (last_hs_c) begin
                valid_d = 1'b0;
            end else begin
                col_d = col_idx_t'(col_q + 1'b1);
            end
        end
    end

    assign valid_o = valid_q;
    assign x_o     = col_q;
    assign y_o     = row_q;
    assign on_o    = buf_q[COLS-1];

endmodule

// File: rtl/playfield_scanner.sv
// Frame scanner: reads every playfield row over port B, streams cells, publishes full rows.
module playfield_scanner
    import playfield_pkg::*;
#(
    parameter int unsigned ROWS         = PF_ROWS,
    parameter int unsigned COLS         = PF_COLS,
    parameter int unsigned READ_LATENCY = PF_READ_LATENCY
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [4:0]      address_b,
    output logic            rden_b,
    input  logic [COLS-1:0] q_b,
    output logic            cell_valid,
    input  logic            cell_ready,
    output logic [3:0]      cell_x,
    output logic [4:0]      cell_y,
    output logic            cell_on,
    output logic [ROWS-1:0] full_rows,
    output logic [4:0]      full_count
);

    localparam int unsigned LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    scan_state_t     state_q, state_d;
    row_addr_t       row_q, row_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [ROWS-1:0] shadow_q, shadow_d;
    logic [ROWS-1:0] full_rows_q, full_rows_d;
    logic [4:0]      full_count_q, full_count_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            rden_q, rden_d;
    row_addr_t       addr_q, addr_d;

    logic            load_c;
    logic            last_hs_c;

    // State, counters, accumulator and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            row_q        <= '0;
            lat_q        <= '0;
            shadow_q     <= '0;
            full_rows_q  <= '0;
            full_count_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rden_q       <= 1'b0;
            addr_q       <= '0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            lat_q        <= lat_d;
            shadow_q     <= shadow_d;
            full_rows_q  <= full_rows_d;
            full_count_q <= full_count_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            rden_q       <= rden_d;
            addr_q       <= addr_d;
        end
    end

    // Next-state and next-output logic; outputs are decoded from the next state so they are registered.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        lat_d        = lat_q;
        shadow_d     = shadow_q;
        full_rows_d  = full_rows_q;
        full_count_d = full_count_q;
        load_c       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    row_d   = '0;
                end
            end
            ST_FETCH: begin
                state_d = ST_WAIT;
                lat_d   = '0;
            end
            ST_WAIT: begin
                if (lat_q == LAT_W'(READ_LATENCY - 1)) begin
                    load_c  = 1'b1;
                    state_d = ST_STREAM;
                    if (&q_b) begin
                        shadow_d[row_q] = 1'b1;
                    end
                end else begin
                    lat_d = LAT_W'(lat_q + 1'b1);
                end
            end
            ST_STREAM: begin
                if (last_hs_c) begin
                    if (row_q == row_addr_t'(ROWS - 1)) begin
                        state_d = ST_FINISH;
                    end else begin
                        row_d   = row_addr_t'(row_q + 1'b1);
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_FETCH) || (state_d == ST_WAIT) || (state_d == ST_STREAM);
        done_d = (state_d == ST_FINISH);
        rden_d = (state_d == ST_FETCH);
        addr_d = (state_d == ST_FETCH) ? row_d : addr_q;

        if (state_d == ST_FINISH) begin
            full_rows_d  = shadow_d;
            full_count_d = 5'(popcount32(32'(shadow_d)));
            shadow_d     = '0;
        end
    end

    // Row-to-cell serialiser, loaded on the edge that captures q_b.
    row_serializer #(
        .COLS(COLS)
    ) u_row_serializer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (load_c),
        .row_word_i (q_b),
        .row_idx_i  (row_q),
        .ready_i    (cell_ready),
        .valid_o    (cell_valid),
        .x_o        (cell_x),
        .y_o        (cell_y),
        .on_o       (cell_on),
        .last_hs_c  (last_hs_c)
    );

    assign busy       = busy_q;
    assign done       = done_q;
    assign rden_b     = rden_q;
    assign address_b  = addr_q;
    assign full_rows  = full_rows_q;
    assign full_count = full_count_q;

endmodule
